rip_branch_resolver: RTL and testbench

RIP_BRANCH_RESOLVER -- requirements
Module: rip_branch_resolver

---
 rtl/rip_branch_resolver.sv | 125 ++++++++++++
 tb/tb_rip_branch_resolver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_branch_resolver.sv
// Branch resolution queue: holds in-flight predictions in FIFO order, trains the
// predictor on resolve, and repairs the speculative global history on mispredict.
module rip_branch_resolver #(
    parameter int unsigned GLOBAL_HISTORY_DEPTH = 10,
    parameter int unsigned QUEUE_DEPTH          = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             pred_valid,
    input  logic [31:0]                      pred_pc,
    input  logic                             pred_taken,
    output logic                             pred_ready,
    input  logic                             res_valid,
    input  logic                             res_taken,
    output logic                             flush,
    output logic                             upd_valid,
    output logic [31:0]                      upd_pc,
    output logic                             upd_taken,
    output logic [GLOBAL_HISTORY_DEPTH-1:0]  upd_history,
    output logic [GLOBAL_HISTORY_DEPTH-1:0]  ghr,
    output logic [$clog2(QUEUE_DEPTH):0]     count,
    output logic                             res_err
);

    localparam int unsigned HW    = GLOBAL_HISTORY_DEPTH;
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]   pc;
        logic          taken;
        logic [HW-1:0] hist;
    } entry_t;

    entry_t             r_queue [QUEUE_DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [HW-1:0]      r_ghr;
    logic               r_flush;
    logic               r_upd_valid;
    logic               r_res_err;
    logic [31:0]        r_upd_pc;
    logic               r_upd_taken;
    logic [HW-1:0]      r_upd_history;

    logic               w_full;
    logic               w_empty;
    logic               w_enq;
    logic               w_res;
    logic               w_mis;
    entry_t             w_head;
    entry_t             w_new;

    // Ready depends only on occupancy; a same-cycle pop never frees a slot early.
    always_comb begin
        w_full  = (r_count == CNT_W'(QUEUE_DEPTH));
        w_empty = (r_count == '0);
        w_enq   = pred_valid && !w_full;
        w_res   = res_valid && !w_empty;
        w_head  = r_queue[r_head];
        w_mis   = w_res && (w_head.taken != res_taken);
        w_new   = '{pc: pred_pc, taken: pred_taken, hist: r_ghr};
    end

    // Entry storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_queue[r_tail] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_ghr         <= '0;
            r_flush       <= 1'b0;
            r_upd_valid   <= 1'b0;
            r_res_err     <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_upd_history <= '0;
        end else begin
            r_flush     <= w_mis;
            r_upd_valid <= w_res;
            r_res_err   <= res_valid && w_empty;

            if (w_res) begin
                r_upd_pc      <= w_head.pc;
                r_upd_taken   <= res_taken;
                r_upd_history <= w_head.hist;
            end

            // A mispredict discards everything, including a same-cycle enqueue.
            if (w_mis) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_ghr   <= {w_head.hist[HW-2:0], res_taken};
            end else begin
                if (w_enq) begin
                    r_tail <= r_tail + PTR_W'(1);
                    r_ghr  <= {r_ghr[HW-2:0], pred_taken};
                end
                if (w_res) begin
                    r_head <= r_head + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_res);
            end
        end
    end

    assign pred_ready  = !w_full;
    assign flush       = r_flush;
    assign upd_valid   = r_upd_valid;
    assign res_err     = r_res_err;
    assign upd_pc      = r_upd_pc;
    assign upd_taken   = r_upd_taken;
    assign upd_history = r_upd_history;
    assign ghr         = r_ghr;
    assign count       = r_count;

endmodule

// File: tb/tb_rip_branch_resolver.sv
// Self-checking bench for rip_branch_resolver: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_rip_branch_resolver;

    localparam int unsigned HW = 10;
    localparam int unsigned QD = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic          pred_ready;
    logic          res_valid;
    logic          res_taken;
    logic          flush;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic          upd_taken;
    logic [HW-1:0] upd_history;
    logic [HW-1:0] ghr;
    logic [CW-1:0] count;
    logic          res_err;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [31:0]   pc;
        logic          t;
        logic [HW-1:0] h;
    } ent_t;

    ent_t          mq[$];
    logic [HW-1:0] m_ghr;
    logic          e_flush, e_upd, e_err, e_t;
    logic [31:0]   e_pc;
    logic [HW-1:0] e_h;

    always #5 clk = ~clk;

    rip_branch_resolver #(.GLOBAL_HISTORY_DEPTH(HW), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rstn(rstn),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .flush(flush), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_history(upd_history),
        .ghr(ghr), .count(count), .res_err(res_err)
    );

    task automatic model_reset();
        mq.delete();
        m_ghr   = '0;
        e_flush = 1'b0; e_upd = 1'b0; e_err = 1'b0;
        e_pc    = '0;   e_t   = 1'b0; e_h   = '0;
    endtask

    // Drive one cycle of stimulus and advance the reference model past that edge.
    task automatic cyc(input logic pv, input logic [31:0] pc, input logic pt,
                       input logic rv, input logic rt);
        bit   enq, res;
        ent_t e, n;
        @(negedge clk);
        pred_valid = pv; pred_pc = pc; pred_taken = pt;
        res_valid  = rv; res_taken = rt;
        enq = pv && (mq.size() < QD);
        res = rv && (mq.size() > 0);
        n.pc = pc; n.t = pt; n.h = m_ghr;
        e_flush = 1'b0;
        e_upd   = res;
        e_err   = rv && (mq.size() == 0);
        if (res) begin
            e    = mq.pop_front();
            e_pc = e.pc; e_t = rt; e_h = e.h;
            if (e.t != rt) begin
                e_flush = 1'b1;
                mq.delete();
                m_ghr = {e.h[HW-2:0], rt};
                enq   = 1'b0;
            end
        end
        if (enq) begin
            mq.push_back(n);
            m_ghr = {m_ghr[HW-2:0], pt};
        end
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rstn = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
        pred_pc = '0; pred_taken = 1'b0; res_taken = 1'b0;
        #12;
        n_chk++; if (count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_chk++; if (ghr !== '0) begin n_err++; $display("FAIL reset_ghr got=%h exp=0", ghr); end
        n_chk++; if ({flush, upd_valid, res_err} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got=%b exp=000", {flush, upd_valid, res_err}); end
        n_chk++; if ({upd_pc, upd_taken, upd_history} !== '0) begin n_err++; $display("FAIL reset_upd got=%h/%b/%h exp=0", upd_pc, upd_taken, upd_history); end
        // Enqueue presented together with reset release must land on the very first edge.
        @(negedge clk);
        rstn = 1'b1; pred_valid = 1'b1; pred_pc = 32'h40; pred_taken = 1'b1;
        #1;
        n_chk++; if (pred_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", pred_ready); end
        @(posedge clk); #1;
        pred_valid = 1'b0;
        n_chk++; if (count !== CW'(1)) begin n_err++; $display("FAIL first_enq_count got=%0d exp=1", count); end
        n_chk++; if (ghr !== HW'(1)) begin n_err++; $display("FAIL first_enq_ghr got=%h exp=1", ghr); end
    endtask

    task automatic test_basic_order();
        logic [31:0]   pcs [3] = '{32'h100, 32'h104, 32'h108};
        logic          tks [3] = '{1'b1, 1'b0, 1'b1};
        logic [HW-1:0] hs  [3] = '{HW'(0), HW'(1), HW'(2)};
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, pcs[i], tks[i], 1'b0, 1'b0);
        n_chk++; if (ghr !== HW'(5)) begin n_err++; $display("FAIL basic_ghr got=%h exp=005", ghr); end
        n_chk++; if (count !== CW'(3)) begin n_err++; $display("FAIL basic_count got=%0d exp=3", count); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, tks[i]);
            n_chk++; if ({upd_valid, flush} !== 2'b10) begin n_err++; $display("FAIL basic_pulse%0d got=%b exp=10", i, {upd_valid, flush}); end
            n_chk++; if (upd_pc !== pcs[i]) begin n_err++; $display("FAIL basic_pc%0d got=%h exp=%h", i, upd_pc, pcs[i]); end
            n_chk++; if (upd_history !== hs[i]) begin n_err++; $display("FAIL basic_hist%0d got=%h exp=%h", i, upd_history, hs[i]); end
        end
        n_chk++; if (count !== '0) begin n_err++; $display("FAIL basic_drain got=%0d exp=0", count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h180 + 32'(4*i), 1'b1, 1'b0, 1'b0);
        n_chk++; if (pred_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%b exp=0", pred_ready); end
        cyc(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        n_chk++; if (count !== CW'(3)) begin n_err++; $display("FAIL full_count got=%0d exp=3", count); end
        n_chk++; if (pred_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after got=%b exp=1", pred_ready); end
        n_chk++; if (upd_pc !== 32'h180) begin n_err++; $display("FAIL full_pc0 got=%h exp=180", upd_pc); end
        for (int i = 1; i < 4; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
            n_chk++; if (upd_pc !== 32'h180 + 32'(4*i)) begin n_err++; $display("FAIL full_pc%0d got=%h exp=%h", i, upd_pc, 32'h180 + 32'(4*i)); end
        end
        n_chk++; if (count !== '0) begin n_err++; $display("FAIL full_drain got=%0d exp=0", count); end
    endtask

    task automatic test_mispredict();
        do_reset();
        cyc(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h104, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_chk++; if ({flush, upd_valid} !== 2'b11) begin n_err++; $display("FAIL mis_pulse got=%b exp=11", {flush, upd_valid}); end
        n_chk++; if ({upd_pc, upd_taken, upd_history} !== {32'h100, 1'b0, HW'(0)}) begin n_err++; $display("FAIL mis_upd got=%h/%b/%h exp=100/0/0", upd_pc, upd_taken, upd_history); end
        n_chk++; if ({count, ghr} !== '0) begin n_err++; $display("FAIL mis_state got=%0d/%h exp=0/0", count, ghr); end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_chk++; if ({flush, upd_valid} !== 2'b00) begin n_err++; $display("FAIL mis_oneshot got=%b exp=00", {flush, upd_valid}); end
        n_chk++; if (upd_pc !== 32'h100) begin n_err++; $display("FAIL mis_hold got=%h exp=100", upd_pc); end
    endtask

    task automatic test_mis_enq();
        do_reset();
        cyc(1'b1, 32'h110, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h300, 1'b1, 1'b1, 1'b0);
        n_chk++; if ({flush, count, ghr} !== {1'b1, CW'(0), HW'(0)}) begin n_err++; $display("FAIL misenq_state got=%b/%0d/%h exp=1/0/0", flush, count, ghr); end
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        n_chk++; if ({res_err, upd_valid} !== 2'b10) begin n_err++; $display("FAIL misenq_err got=%b exp=10", {res_err, upd_valid}); end
        n_chk++; if (upd_pc !== 32'h110) begin n_err++; $display("FAIL misenq_pc got=%h exp=110", upd_pc); end
    endtask

    task automatic test_empty_resolve();
        do_reset();
        cyc(1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_chk++; if ({res_err, upd_valid, flush} !== 3'b100) begin n_err++; $display("FAIL empty_pulses got=%b exp=100", {res_err, upd_valid, flush}); end
        n_chk++; if ({count, ghr} !== {CW'(0), HW'(1)}) begin n_err++; $display("FAIL empty_state got=%0d/%h exp=0/001", count, ghr); end
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_chk++; if (res_err !== 1'b0) begin n_err++; $display("FAIL empty_oneshot got=%b exp=0", res_err); end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [22];
        logic        tks [22];
        for (int i = 0; i < 22; i++) begin
            pcs[i] = 32'h1000 + 32'(4*i);
            tks[i] = 1'($urandom);
        end
        do_reset();
        cyc(1'b1, pcs[0], tks[0], 1'b0, 1'b0);
        cyc(1'b1, pcs[1], tks[1], 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, pcs[k+2], tks[k+2], 1'b1, tks[k]);
            n_chk++; if ({upd_valid, flush, upd_pc} !== {2'b10, pcs[k]}) begin n_err++; $display("FAIL wrap_pc%0d got=%b%b/%h exp=10/%h", k, upd_valid, flush, upd_pc, pcs[k]); end
            n_chk++; if (count !== CW'(2)) begin n_err++; $display("FAIL wrap_count%0d got=%0d exp=2", k, count); end
        end
    endtask

    task automatic test_random();
        logic        pv, pt, rv, rt;
        logic [31:0] pc;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 rstn = 1'b0;
                #1;
                n_chk++; if ({count, ghr, flush, upd_valid} !== '0) begin n_err++; $display("FAIL rand_midreset got=%0d/%h/%b/%b exp=0", count, ghr, flush, upd_valid); end
                model_reset();
                @(negedge clk) rstn = 1'b1;
            end
            n_chk++; if (pred_ready !== (mq.size() < QD)) begin n_err++; $display("FAIL rand_ready%0d got=%b exp=%b", i, pred_ready, mq.size() < QD); end
            pv = ($urandom % 4) != 0;
            pc = $urandom & 32'hffff_fffc;
            pt = 1'($urandom);
            rv = ($urandom % 3) == 0;
            rt = (mq.size() > 0 && ($urandom % 5) != 0) ? mq[0].t : 1'($urandom);
            cyc(pv, pc, pt, rv, rt);
            n_chk++;
            if ({flush, upd_valid, res_err, upd_pc, upd_taken, upd_history, ghr, count} !==
                {e_flush, e_upd, e_err, e_pc, e_t, e_h, m_ghr, CW'(mq.size())}) begin
                n_err++;
                $display("FAIL rand_cycle%0d got=%b%b%b pc=%h t=%b h=%h ghr=%h cnt=%0d exp=%b%b%b pc=%h t=%b h=%h ghr=%h cnt=%0d",
                         i, flush, upd_valid, res_err, upd_pc, upd_taken, upd_history, ghr, count,
                         e_flush, e_upd, e_err, e_pc, e_t, e_h, m_ghr, mq.size());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_order();
        test_full();
        test_mispredict();
        test_mis_enq();
        test_empty_resolve();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
